// File: rtl/lut_config_sequencer.sv
// Byte-serial LUT configuration sequencer: assembles one frame, then pulses cen to one target.
// Optional feature macro: LUT_CFG_CHECKSUM_EN (trailing XOR checksum word per frame).
module lut_config_sequencer #(
  parameter int INPUTS      = 4,
  parameter int MEM_SIZE    = 2**INPUTS,
  parameter int CFG_W       = 2*MEM_SIZE,
  parameter int WORD_W      = 8,
  parameter int NUM_TARGETS = 4
) (
  input  logic                   cclk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CFG_W-1:0]       config_out,
  output logic [NUM_TARGETS-1:0] cen_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int NWORDS = CFG_W / WORD_W;
  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_DROP
`ifdef LUT_CFG_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_ready;
  logic                     w_xfer;
  logic                     w_last;
  logic [IDX_W-1:0]         w_hdr_idx;
  logic                     w_hdr_bad;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_bad;
  logic [CNT_W-1:0]         r_cnt;
  logic [CFG_W-1:0]         r_config;
  logic [NUM_TARGETS-1:0]   r_cen;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
`ifdef LUT_CFG_CHECKSUM_EN
  logic [WORD_W-1:0]        r_csum;
`endif

  // With one target there are no index bits; every header addresses target 0.
  assign w_hdr_idx = (NUM_TARGETS == 1) ? '0 : in_data[IDX_W-1:0];
  assign w_hdr_bad = 32'(w_hdr_idx) >= 32'(NUM_TARGETS);
  assign w_xfer    = in_valid & w_ready;
  assign w_last    = (r_cnt == CNT_W'(NWORDS - 1));

  // in_ready depends on state only, so no in_valid -> in_ready path exists.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: w_ready = 1'b1;
`ifdef LUT_CFG_CHECKSUM_EN
      S_CHECK:        w_ready = 1'b1;
`endif
      default:        w_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = S_LOAD;
      S_LOAD: begin
        if (w_xfer && w_last) begin
`ifdef LUT_CFG_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = r_bad ? S_DROP : S_COMMIT;
`endif
        end
      end
`ifdef LUT_CFG_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_next = (!r_bad && (in_data == r_csum)) ? S_COMMIT : S_DROP;
`endif
      S_COMMIT, S_DROP: w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_bad    <= 1'b0;
      r_cnt    <= '0;
      r_config <= '0;
      r_cen    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_COMMIT);
      r_err  <= (r_state == S_DROP);
      r_cen  <= (w_next == S_COMMIT) ? (NUM_TARGETS'(1) << r_idx) : '0;
      if (r_state == S_IDLE && w_xfer) begin
        r_idx <= w_hdr_idx;
        r_bad <= w_hdr_bad;
        r_cnt <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
        r_csum <= in_data;
`endif
      end
      if (r_state == S_LOAD && w_xfer) begin
        r_config <= (r_config << WORD_W) | CFG_W'(in_data);
        r_cnt    <= r_cnt + CNT_W'(1);
`ifdef LUT_CFG_CHECKSUM_EN
        r_csum   <= r_csum ^ in_data;
`endif
      end
    end
  end

  assign in_ready   = w_ready;
  assign config_out = r_config;
  assign cen_out    = r_cen;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
